// File: rtl/dmem_arbiter.sv
// Two-port data-memory arbiter: port 0 (core load/store) and port 1
// (loader/debug) share one single-ported memory. Ownership alternates under
// contention after MAX_BURST accepted transactions. Read data is returned
// one cycle after acceptance on the port that issued the read.
module dmem_arbiter #(
   parameter int MAX_BURST = 4,
   parameter int DW        = 32
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          req0,
   input  logic          req1,
   input  logic          we0,
   input  logic          we1,
   input  logic [DW-1:0] addr0,
   input  logic [DW-1:0] addr1,
   input  logic [DW-1:0] wdata0,
   input  logic [DW-1:0] wdata1,
   output logic          gnt0,
   output logic          gnt1,
   output logic          rvalid0,
   output logic          rvalid1,
   output logic [DW-1:0] rdata0,
   output logic [DW-1:0] rdata1,
   output logic          mem_we,
   output logic [DW-1:0] mem_addr,
   output logic [DW-1:0] mem_wdata,
   input  logic [DW-1:0] mem_rdata
);

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] OWN0 = 2'd1;
   localparam logic [1:0] OWN1 = 2'd2;

   localparam logic [3:0] BURST_MAX = 4'(MAX_BURST);

   logic [1:0]    state_r;
   logic [1:0]    next_state_s;
   logic          last_owner_r;
   logic          next_last_owner_s;
   logic [3:0]    burst_cnt_r;
   logic [3:0]    next_burst_cnt_s;
   logic [3:0]    burst_inc_s;
   logic          burst_done_s;
   logic          rvalid0_r;
   logic          rvalid1_r;
   logic [DW-1:0] rdata0_r;
   logic [DW-1:0] rdata1_r;

   // Grants are the owner's live request; an unaccepted request is never stored.
   assign gnt0 = (state_r == OWN0) & req0;
   assign gnt1 = (state_r == OWN1) & req1;

   assign burst_inc_s  = burst_cnt_r + 4'd1;
   assign burst_done_s = (burst_inc_s == BURST_MAX);

   assign rvalid0 = rvalid0_r;
   assign rvalid1 = rvalid1_r;
   assign rdata0  = rdata0_r;
   assign rdata1  = rdata1_r;

   // Next-state, burst counter and fairness bookkeeping.
   always_comb begin
      next_state_s      = state_r;
      next_last_owner_s = last_owner_r;
      next_burst_cnt_s  = burst_cnt_r;
      case (state_r)
         IDLE: begin
            next_burst_cnt_s = 4'd0;
            if (req0 && req1) begin
               // Tie goes to the port that did not own the bus last.
               next_state_s = last_owner_r ? OWN0 : OWN1;
            end else if (req0) begin
               next_state_s = OWN0;
            end else if (req1) begin
               next_state_s = OWN1;
            end else begin
               next_state_s = IDLE;
            end
         end
         OWN0: begin
            if (!req0) begin
               next_state_s      = req1 ? OWN1 : IDLE;
               next_burst_cnt_s  = 4'd0;
               next_last_owner_s = 1'b0;
            end else if (!burst_done_s) begin
               next_state_s     = OWN0;
               next_burst_cnt_s = burst_inc_s;
            end else if (req1) begin
               next_state_s      = OWN1;
               next_burst_cnt_s  = 4'd0;
               next_last_owner_s = 1'b0;
            end else begin
               // Nobody waiting: keep the bus, just restart the burst count.
               next_state_s     = OWN0;
               next_burst_cnt_s = 4'd0;
            end
         end
         OWN1: begin
            if (!req1) begin
               next_state_s      = req0 ? OWN0 : IDLE;
               next_burst_cnt_s  = 4'd0;
               next_last_owner_s = 1'b1;
            end else if (!burst_done_s) begin
               next_state_s     = OWN1;
               next_burst_cnt_s = burst_inc_s;
            end else if (req0) begin
               next_state_s      = OWN0;
               next_burst_cnt_s  = 4'd0;
               next_last_owner_s = 1'b1;
            end else begin
               next_state_s     = OWN1;
               next_burst_cnt_s = 4'd0;
            end
         end
         default: begin
            next_state_s     = IDLE;
            next_burst_cnt_s = 4'd0;
         end
      endcase
   end

   // Arbitration state registers.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_r      <= IDLE;
         last_owner_r <= 1'b1;
         burst_cnt_r  <= 4'd0;
      end else begin
         state_r      <= next_state_s;
         last_owner_r <= next_last_owner_s;
         burst_cnt_r  <= next_burst_cnt_s;
      end
   end

   // Memory-side mux: granted port drives the memory, otherwise all zero.
   always_comb begin
      mem_we    = 1'b0;
      mem_addr  = {DW{1'b0}};
      mem_wdata = {DW{1'b0}};
      if (gnt0) begin
         mem_we    = we0;
         mem_addr  = addr0;
         mem_wdata = wdata0;
      end else if (gnt1) begin
         mem_we    = we1;
         mem_addr  = addr1;
         mem_wdata = wdata1;
      end else begin
         mem_we    = 1'b0;
         mem_addr  = {DW{1'b0}};
         mem_wdata = {DW{1'b0}};
      end
   end

   // Read responses: capture memory data one cycle after an accepted read.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rvalid0_r <= 1'b0;
         rvalid1_r <= 1'b0;
         rdata0_r  <= {DW{1'b0}};
         rdata1_r  <= {DW{1'b0}};
      end else begin
         rvalid0_r <= gnt0 & ~we0;
         rvalid1_r <= gnt1 & ~we1;
         if (gnt0 && !we0) begin
            rdata0_r <= mem_rdata;
         end
         if (gnt1 && !we1) begin
            rdata1_r <= mem_rdata;
         end
      end
   end

endmodule
